// File: rtl/chronologic_pkg.sv
// Shared defaults and types for the chronologic same-cycle mirror checker.
package chronologic_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/chronologic_sat_cnt.sv
// Saturating up-counter with synchronous reset and a clear that can coincide with an increment.
module chronologic_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // A clear on the same edge as an increment leaves the new event counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/chronologic.sv
// Same-cycle reflection checker: flags every edge where y differs from x, with stats and capture.
module chronologic
  import chronologic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             clr_err,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic [WIDTH-1:0] mismatch_bits
);

  // rst_n is active-high: 1 holds the checker in reset.
  logic rst;
  logic match;
  logic mismatch;

  assign rst      = rst_n;
  assign match    = (x == y);
  assign mismatch = ~match;

  chronologic_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (1'b0),
    .count (pass_cnt)
  );

  chronologic_sat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch),
    .clr   (clr_err),
    .count (fail_cnt)
  );

  chronologic_sat_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .clr   (1'b0),
    .count (cycle_cnt)
  );

  // Unknown bits make the compare non-true, so they fall into the fail branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_pulse       <= 1'b0;
      fail_pulse       <= 1'b0;
      err_sticky       <= 1'b0;
      first_fail_cycle <= '0;
      mismatch_bits    <= '0;
    end else if (match) begin
      pass_pulse <= 1'b1;
      fail_pulse <= 1'b0;
      if (clr_err) begin
        err_sticky       <= 1'b0;
        first_fail_cycle <= '0;
        mismatch_bits    <= '0;
      end
    end else begin
      pass_pulse    <= 1'b0;
      fail_pulse    <= 1'b1;
      err_sticky    <= 1'b1;
      mismatch_bits <= x ^ y;
      if (!err_sticky || clr_err) begin
        first_fail_cycle <= cycle_cnt;
      end
    end
  end

endmodule

// File: tb/tb_chronologic.sv
// Randomized bench for chronologic: two instances (16-bit and 4-bit counters) against a behavioural model.
module tb_chronologic;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         clr_err = 1'b0;

  logic         b_pp, b_fp, b_err;
  logic [15:0]  b_pc, b_fc, b_cc, b_ffc;
  logic [W-1:0] b_mm;
  logic         s_pp, s_fp, s_err;
  logic [3:0]   s_pc, s_fc, s_cc, s_ffc;
  logic [W-1:0] s_mm;

  chronologic #(.WIDTH(W), .CNT_W(16)) dut_big (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .clr_err(clr_err),
    .pass_pulse(b_pp), .fail_pulse(b_fp), .err_sticky(b_err),
    .pass_cnt(b_pc), .fail_cnt(b_fc), .cycle_cnt(b_cc),
    .first_fail_cycle(b_ffc), .mismatch_bits(b_mm)
  );

  chronologic #(.WIDTH(W), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .clr_err(clr_err),
    .pass_pulse(s_pp), .fail_pulse(s_fp), .err_sticky(s_err),
    .pass_cnt(s_pc), .fail_cnt(s_fc), .cycle_cnt(s_cc),
    .first_fail_cycle(s_ffc), .mismatch_bits(s_mm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = 16-bit counters, 1 = 4-bit counters.
  int m_max[2] = '{65535, 15};
  int m_pc[2], m_fc[2], m_cc[2], m_ffc[2];
  bit m_pp[2], m_fp[2], m_err[2];
  int m_mm[2];
  bit started = 1'b0;

  function automatic int sat_add(int v, int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        m_pc[k] = 0; m_fc[k] = 0; m_cc[k] = 0; m_ffc[k] = 0;
        m_pp[k] = 0; m_fp[k] = 0; m_err[k] = 0; m_mm[k] = 0;
      end else begin
        bit ok;
        bit had_err;
        ok = (x === y);
        had_err = clr_err ? 1'b0 : m_err[k];
        if (clr_err) begin
          m_fc[k] = 0; m_err[k] = 0; m_ffc[k] = 0; m_mm[k] = 0;
        end
        m_pp[k] = ok;
        m_fp[k] = !ok;
        if (ok) begin
          m_pc[k] = sat_add(m_pc[k], m_max[k]);
        end else begin
          if (!had_err) m_ffc[k] = m_cc[k];
          m_fc[k] = sat_add(m_fc[k], m_max[k]);
          m_err[k] = 1'b1;
          m_mm[k] = int'(x ^ y);
        end
        m_cc[k] = sat_add(m_cc[k], m_max[k]);
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("big.pass_pulse", b_pp, m_pp[0]);
      check("big.fail_pulse", b_fp, m_fp[0]);
      check("big.err_sticky", b_err, m_err[0]);
      check("big.pass_cnt", b_pc, m_pc[0]);
      check("big.fail_cnt", b_fc, m_fc[0]);
      check("big.cycle_cnt", b_cc, m_cc[0]);
      check("big.first_fail_cycle", b_ffc, m_ffc[0]);
      check("big.mismatch_bits", b_mm, m_mm[0]);
      check("small.pass_pulse", s_pp, m_pp[1]);
      check("small.fail_pulse", s_fp, m_fp[1]);
      check("small.err_sticky", s_err, m_err[1]);
      check("small.pass_cnt", s_pc, m_pc[1]);
      check("small.fail_cnt", s_fc, m_fc[1]);
      check("small.cycle_cnt", s_cc, m_cc[1]);
      check("small.first_fail_cycle", s_ffc, m_ffc[1]);
      check("small.mismatch_bits", s_mm, m_mm[1]);
      check("big.pulse_exclusive", b_pp & b_fp, 0);
    end
  end

  task automatic drive(logic r, logic [W-1:0] xv, logic [W-1:0] yv, logic c);
    rst_n = r; x = xv; y = yv; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Held in reset with differing inputs: nothing may be flagged.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 8'h01, 1'b0);
    check("lit.reset_fail_pulse", b_fp, 0);
    check("lit.reset_err", b_err, 0);
    check("lit.reset_fail_cnt", b_fc, 0);

    for (int i = 0; i < 4; i++) drive(1'b0, 8'hA5, 8'hA5, 1'b0);
    check("lit.pass_cnt_4", b_pc, 4);
    check("lit.cycle_cnt_4", b_cc, 4);
    check("lit.fail_cnt_0", b_fc, 0);

    drive(1'b0, 8'h01, 8'h00, 1'b0);
    check("lit.fail_pulse", b_fp, 1);
    check("lit.ffc_4", b_ffc, 4);
    check("lit.mm_01", b_mm, 8'h01);
    drive(1'b0, 8'h03, 8'h00, 1'b0);
    check("lit.ffc_kept_4", b_ffc, 4);
    check("lit.fail_cnt_2", b_fc, 2);

    drive(1'b0, 8'h02, 8'h00, 1'b1);
    check("lit.clr_fail_err", b_err, 1);
    check("lit.clr_fail_cnt", b_fc, 1);
    check("lit.clr_fail_ffc", b_ffc, 6);
    drive(1'b0, 8'h5A, 8'h5A, 1'b1);
    check("lit.clr_pass_err", b_err, 0);
    check("lit.clr_pass_fail_cnt", b_fc, 0);
    check("lit.clr_pass_pass_cnt", b_pc, 5);

    for (int i = 0; i < 20; i++) drive(1'b0, 8'h3C, 8'h3C, 1'b0);
    check("lit.small_pass_sat", s_pc, 15);
    check("lit.small_cycle_sat", s_cc, 15);
    check("lit.big_pass_25", b_pc, 25);
    check("lit.big_cycle_28", b_cc, 28);

    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] xv, yv;
      xv = W'($urandom);
      yv = ($urandom_range(1) == 1) ? xv : W'($urandom);
      drive($urandom_range(19) == 0, xv, yv, $urandom_range(7) == 0);
    end

    drive(1'b0, 8'h10, 8'h10, 1'b0);
    drive(1'b0, 8'h10, 8'h20, 1'b0);
    drive(1'b0, 8'h44, 8'h40, 1'b0);
    drive(1'b1, 8'h33, 8'h11, 1'b1);
    check("lit.midreset_fail_pulse", b_fp, 0);
    check("lit.midreset_err", b_err, 0);
    check("lit.midreset_fail_cnt", b_fc, 0);
    check("lit.midreset_cycle_cnt", b_cc, 0);
    check("lit.midreset_mm", b_mm, 0);
    drive(1'b0, 8'h77, 8'h77, 1'b0);
    drive(1'b0, 8'h77, 8'h77, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
